axil_arbiter_rd: RTL and testbench

Round-robin read-channel arbiter for the AXI-Lite interconnect. Samples the per-master `m_axil_arvalid` requests and drives a one-hot `grant_rd` vector to the read crossbar mux directly downstream. Holds the grant for one complete AXI-Lite read transaction, from the AR handshake through the R handshake, observed on the slave side of the mux. One arbiter instance serves each slave port.

---
 rtl/axil_arbiter_rd.sv | 156 +++++++++++++++
 tb/tb_axil_arbiter_rd.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_arbiter_rd.sv
// Round-robin AXI-Lite read-channel arbiter: holds a one-hot grant for one AR+R transaction.
// Optional watchdog abort enabled by defining AXIL_ARB_RD_TIMEOUT_EN.
module axil_arbiter_rd #(
  parameter int unsigned NUMBER_MASTER = 2,
  parameter int unsigned ARB_TIMEOUT   = 256
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUMBER_MASTER-1:0] m_axil_arvalid,
  input  logic                     s_axil_arvalid,
  input  logic                     s_axil_arready,
  input  logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic [NUMBER_MASTER-1:0] grant_rd,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUMBER_MASTER);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUMBER_MASTER - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e                   state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic                     busy_q, busy_d;
  logic [IDX_W-1:0]         last_idx_q, last_idx_d;
  logic [IDX_W-1:0]         gnt_idx_q, gnt_idx_d;

  logic                     ar_hs, r_hs;
  logic                     req_found;
  logic [IDX_W-1:0]         req_idx;
  logic [IDX_W-1:0]         cand;
  logic                     abort;

  assign ar_hs = s_axil_arvalid && s_axil_arready;
  assign r_hs  = s_axil_rvalid && s_axil_rready;

  // Search upward from last_idx+1 with explicit wrap so non-power-of-2 counts work.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = last_idx_q;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      cand = (cand == IDX_MAX) ? '0 : cand + IDX_W'(1);
      if (!req_found && m_axil_arvalid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

`ifdef AXIL_ARB_RD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(ARB_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ARB_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  // Watchdog fires on the cycle whose increment would reach ARB_TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    abort = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      abort = (cnt_q >= CNT_LAST);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
    // A handshake on the same edge takes precedence over the abort.
    tmo_d = abort && !((state_q == ADDR) && ar_hs) && !((state_q == DATA) && r_hs);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    last_idx_d = last_idx_q;
    gnt_idx_d  = gnt_idx_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d   = ADDR;
          grant_d   = NUMBER_MASTER'(1) << req_idx;
          busy_d    = 1'b1;
          gnt_idx_d = req_idx;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          state_d = DATA;
        end else if (abort) begin
          state_d    = IDLE;
          grant_d    = '0;
          busy_d     = 1'b0;
          last_idx_d = gnt_idx_q;
        end
      end
      DATA: begin
        if (r_hs || abort) begin
          state_d    = IDLE;
          grant_d    = '0;
          busy_d     = 1'b0;
          last_idx_d = gnt_idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset leaves last_idx at the top index so master 0 wins first.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      last_idx_q <= IDX_MAX;
      gnt_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      last_idx_q <= last_idx_d;
      gnt_idx_q  <= gnt_idx_d;
    end
  end

  assign grant_rd = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axil_arbiter_rd.sv
// Self-checking bench for axil_arbiter_rd: 4-master and 3-master instances, grant scoreboard.
module tb_axil_arbiter_rd;

  localparam int unsigned NM  = 4;
  localparam int unsigned TMO = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [NM-1:0] m_arv = '0;
  logic [2:0]    m3_arv = '0;
  logic          s_arv = 1'b0, s_arr = 1'b0, s_rv = 1'b0, s_rr = 1'b0;
  logic [NM-1:0] grant;
  logic          busy, tmo_err;
  logic [2:0]    grant3;
  logic          busy3, tmo_err3;

  int checks = 0;
  int failures = 0;
  logic [NM-1:0] exp_q[$];
  logic [NM-1:0] prev_grant = '0;
  logic [NM-1:0] sb_exp;

  always #5 aclk = ~aclk;

  axil_arbiter_rd #(.NUMBER_MASTER(NM), .ARB_TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset), .m_axil_arvalid(m_arv),
    .s_axil_arvalid(s_arv), .s_axil_arready(s_arr),
    .s_axil_rvalid(s_rv), .s_axil_rready(s_rr),
    .grant_rd(grant), .busy(busy), .timeout_err(tmo_err)
  );

  axil_arbiter_rd #(.NUMBER_MASTER(3), .ARB_TIMEOUT(TMO)) dut3 (
    .aclk(aclk), .areset(areset), .m_axil_arvalid(m3_arv),
    .s_axil_arvalid(s_arv), .s_axil_arready(s_arr),
    .s_axil_rvalid(s_rv), .s_axil_rready(s_rr),
    .grant_rd(grant3), .busy(busy3), .timeout_err(tmo_err3)
  );

  // Scoreboard: every new non-zero grant must match the oldest queued expectation.
  always @(negedge aclk) begin
    if (!areset && grant !== prev_grant && grant !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_grant got=%b expected=none", grant);
      end else begin
        sb_exp = exp_q.pop_front();
        if (grant !== sb_exp) begin
          failures++;
          $display("FAIL sb_grant got=%b expected=%b", grant, sb_exp);
        end
      end
      checks++;
      if ($countones(grant) != 1) begin
        failures++;
        $display("FAIL onehot got=%b expected=one bit set", grant);
      end
    end
    prev_grant = grant;
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    m_arv = '0; m3_arv = '0;
    s_arv = 1'b0; s_arr = 1'b0; s_rv = 1'b0; s_rr = 1'b0;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (grant === '0 && grant3 === '0 && n < 8);
  endtask

  // AR handshake, then R handshake on the next cycle.
  task automatic complete();
    s_arv = 1'b1; s_arr = 1'b1;
    step();
    s_arv = 1'b0; s_arr = 1'b0; s_rv = 1'b1; s_rr = 1'b1;
    step();
    s_rv = 1'b0; s_rr = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    step();
    checks++; if (grant !== '0) begin failures++; $display("FAIL reset_grant got=%b expected=0000", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
    checks++; if (tmo_err !== 1'b0 || tmo_err3 !== 1'b0) begin failures++; $display("FAIL reset_tmo got=%b/%b expected=0/0", tmo_err, tmo_err3); end
    areset = 1'b0;
    m_arv = 4'b1111;
    exp_q.push_back(4'b0001);
    step();
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL reset_prio got=%b expected=0001", grant); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_prio_busy got=%b expected=1", busy); end
    m_arv = '0;
    complete();
    checks++; if (grant !== '0 || busy !== 1'b0) begin failures++; $display("FAIL release got=%b/%b expected=0000/0", grant, busy); end
  endtask

  task automatic test_rotation();
    int n;
    do_reset();
    m_arv = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(4'(1) << (i % 4));
      wait_grant(n);
      checks++;
      if (n != 1) begin failures++; $display("FAIL rot_latency[%0d] got=%0d expected=1", i, n); end
      complete();
      checks++;
      if (grant !== '0) begin failures++; $display("FAIL rot_idle[%0d] got=%b expected=0000", i, grant); end
    end
    m_arv = '0;
    step();
  endtask

  task automatic test_grant_hold();
    int n;
    do_reset();
    m_arv = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(n);
    checks++; if (n != 1) begin failures++; $display("FAIL hold_latency got=%0d expected=1", n); end
    m_arv = 4'b0100;
    s_rv = 1'b1; s_rr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (grant !== 4'b0010) begin failures++; $display("FAIL hold_addr[%0d] got=%b expected=0010", k, grant); end
    end
    s_rv = 1'b0; s_rr = 1'b0;
    s_arv = 1'b1; s_arr = 1'b1;
    step();
    s_arv = 1'b0; s_arr = 1'b0;
    checks++; if (grant !== 4'b0010 || busy !== 1'b1) begin failures++; $display("FAIL hold_data got=%b/%b expected=0010/1", grant, busy); end
    s_rv = 1'b1; s_rr = 1'b1;
    step();
    s_rv = 1'b0; s_rr = 1'b0;
    checks++; if (grant !== '0) begin failures++; $display("FAIL hold_release got=%b expected=0000", grant); end
    exp_q.push_back(4'b0100);
    step();
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL hold_next got=%b expected=0100", grant); end
    m_arv = '0;
    complete();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    m3_arv = 3'b101;
    step();
    checks++; if (grant3 !== 3'b001 || busy3 !== 1'b1) begin failures++; $display("FAIL wrap_first got=%b/%b expected=001/1", grant3, busy3); end
    complete();
    checks++; if (grant3 !== '0) begin failures++; $display("FAIL wrap_release got=%b expected=000", grant3); end
    step();
    checks++; if (grant3 !== 3'b100) begin failures++; $display("FAIL wrap_second got=%b expected=100", grant3); end
    complete();
    step();
    checks++; if (grant3 !== 3'b001) begin failures++; $display("FAIL wrap_around got=%b expected=001", grant3); end
    m3_arv = '0;
    complete();
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    m_arv = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(n);
    m_arv = '0;
    s_arv = 1'b1; s_arr = 1'b1;
    step();
    s_arv = 1'b0; s_arr = 1'b0;
    checks++; if (busy !== 1'b1 || grant !== 4'b0001) begin failures++; $display("FAIL mid_data got=%b/%b expected=0001/1", grant, busy); end
    areset = 1'b1;
    m_arv = 4'b1000;
    step();
    checks++; if (grant !== '0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b/%b expected=0000/0", grant, busy); end
    areset = 1'b0;
    exp_q.push_back(4'b1000);
    step();
    checks++; if (grant !== 4'b1000 || busy !== 1'b1) begin failures++; $display("FAIL mid_regrant got=%b/%b expected=1000/1", grant, busy); end
    m_arv = '0;
    complete();
    step();
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    m_arv = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(n);
    m_arv = '0;
    s_arv = 1'b1; s_arr = 1'b1;
    step();
    s_arv = 1'b0; s_arr = 1'b0;
`ifdef AXIL_ARB_RD_TIMEOUT_EN
    for (int k = 2; k <= 15; k++) step();
    checks++; if (grant !== 4'b0001 || tmo_err !== 1'b0) begin failures++; $display("FAIL wd_pre got=%b/%b expected=0001/0", grant, tmo_err); end
    step();
    checks++; if (grant !== '0 || busy !== 1'b0) begin failures++; $display("FAIL wd_abort got=%b/%b expected=0000/0", grant, busy); end
    checks++; if (tmo_err !== 1'b1) begin failures++; $display("FAIL wd_pulse got=%b expected=1", tmo_err); end
    m_arv = 4'b1111;
    exp_q.push_back(4'b0010);
    step();
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL wd_pulse_end got=%b expected=0", tmo_err); end
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL wd_next got=%b expected=0010", grant); end
    m_arv = '0;
    complete();
    step();
`else
    repeat (999) step();
    checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL wd_hold got=%b/%b expected=0001/1", grant, busy); end
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL wd_tied got=%b expected=0", tmo_err); end
    do_reset();
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_grant_hold();
    test_wrap();
    test_reset_mid();
    test_watchdog();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
